// File: rtl/atm_account_arbiter.sv
// Two-terminal round-robin arbiter for a shared single-port balance memory.
// Ports: req/we/card_number/wdata/session per terminal, ack/conflict/rdata back, mem_* to the store.
module atm_account_arbiter #(
  parameter int card_width    = 3,
  parameter int balance_width = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req,
  input  logic [1:0]                 we,
  input  logic [2*card_width-1:0]    card_number,
  input  logic [2*balance_width-1:0] wdata,
  input  logic [1:0]                 session,
  output logic [1:0]                 ack,
  output logic [1:0]                 conflict,
  output logic [balance_width-1:0]   rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [card_width-1:0]      mem_addr,
  output logic [balance_width-1:0]   mem_wdata,
  input  logic [balance_width-1:0]   mem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] ACK     = 2'd3;

  logic [1:0]               state;
  logic                     g;
  logic                     we_l;
  logic [card_width-1:0]    card_l;
  logic [balance_width-1:0] wdata_l;
  logic                     blocked;
  logic                     last_grant;
  logic [1:0]               lock_valid;
  logic [card_width-1:0]    lock_card [2];

  logic                     pick;
  logic [card_width-1:0]    card_sel;
  logic [balance_width-1:0] wdata_sel;
  logic                     blk;

  // Tie goes to whoever did not win last time.
  always_comb begin
    pick      = (req == 2'b11) ? ~last_grant : req[1];
    card_sel  = pick ? card_number[2*card_width-1:card_width]
                     : card_number[card_width-1:0];
    wdata_sel = pick ? wdata[2*balance_width-1:balance_width]
                     : wdata[balance_width-1:0];
    blk       = lock_valid[~pick] && (lock_card[~pick] == card_sel);
  end

  // Every output is registered on the edge that enters the state it
  // belongs to, so mem_en is high throughout ISSUE and ack throughout ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      g            <= 1'b0;
      we_l         <= 1'b0;
      card_l       <= '0;
      wdata_l      <= '0;
      blocked      <= 1'b0;
      last_grant   <= 1'b1;
      lock_valid   <= 2'b00;
      lock_card[0] <= '0;
      lock_card[1] <= '0;
      ack          <= 2'b00;
      conflict     <= 2'b00;
      rdata        <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      ack      <= 2'b00;
      conflict <= 2'b00;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            g          <= pick;
            we_l       <= we[pick];
            card_l     <= card_sel;
            wdata_l    <= wdata_sel;
            blocked    <= blk;
            last_grant <= pick;
            mem_en     <= ~blk;
            mem_we     <= we[pick] & ~blk;
            mem_addr   <= card_sel;
            mem_wdata  <= wdata_sel;
            state      <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          if (blocked)   rdata <= '0;
          else if (we_l) rdata <= wdata_l;
          else           rdata <= mem_rdata;
          ack      <= g ? 2'b10 : 2'b01;
          conflict <= blocked ? (g ? 2'b10 : 2'b01) : 2'b00;
          state    <= CAPTURE + 2'd1;
        end
        ACK: begin
          if (!blocked && session[g]) begin
            lock_valid[g] <= 1'b1;
            lock_card[g]  <= card_l;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Session drop wins over a same-cycle lock set.
      for (int i = 0; i < 2; i++)
        if (!session[i]) lock_valid[i] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed bench for atm_account_arbiter with a 1-cycle-latency memory model.
// Memory reloads a fixed pattern whenever rst is high.
module tb_atm_account_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [5:0]  card_number;
  logic [39:0] wdata;
  logic [1:0]  session;
  logic [1:0]  ack;
  logic [1:0]  conflict;
  logic [19:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  mem_addr;
  logic [19:0] mem_wdata;
  logic [19:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [19:0] mem [8];
  int          en_cnt = 0;
  logic [2:0]  last_addr;
  logic        last_we;

  atm_account_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .card_number(card_number), .wdata(wdata), .session(session),
    .ack(ack), .conflict(conflict), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++)
        mem[i] <= (i == 5) ? 20'd1000 : 20'(i * 111);
      mem_rdata <= '0;
    end else if (mem_en) begin
      en_cnt++;
      last_addr = mem_addr;
      last_we   = mem_we;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic access(input int r, input logic w, input int card,
                        input logic [19:0] d, input logic s,
                        output int lat, output logic [19:0] rd,
                        output logic cf);
    logic [2:0] c3;
    c3 = card[2:0];
    @(negedge clk);
    req[r] = 1'b1;
    we[r] = w;
    card_number[r*3 +: 3] = c3;
    wdata[r*20 +: 20] = d;
    session[r] = s;
    lat = 0;
    rd = '0;
    cf = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (ack[r]) begin
        lat = c;
        rd = rdata;
        cf = conflict[r];
        break;
      end
    end
    if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
    @(negedge clk);
    req[r] = 1'b0;
  endtask

  int          lat;
  logic [19:0] rd;
  logic        cf;
  int          e0;
  int          n;
  int          who [4];
  int          when [4];
  logic [19:0] val [4];

  initial begin
    rst = 1'b1;
    req = '0; we = '0; card_number = '0; wdata = '0; session = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem", 32'({mem_en, mem_we, mem_addr}), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single read
    e0 = en_cnt;
    access(0, 1'b0, 5, 20'd0, 1'b0, lat, rd, cf);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", 32'(rd), 32'd1000);
    chk("rd_conflict", 32'(cf), 32'd0);
    chk("rd_en_pulses", 32'(en_cnt - e0), 32'd1);
    chk("rd_addr", 32'(last_addr), 32'd5);
    chk("rd_we", 32'(last_we), 32'd0);

    // write then read
    e0 = en_cnt;
    access(1, 1'b1, 2, 20'd750, 1'b0, lat, rd, cf);
    chk("wr_echo", 32'(rd), 32'd750);
    chk("wr_we", 32'(last_we), 32'd1);
    access(0, 1'b0, 2, 20'd0, 1'b0, lat, rd, cf);
    chk("wr_readback", 32'(rd), 32'd750);
    chk("wr_en_pulses", 32'(en_cnt - e0), 32'd2);

    // simultaneous requests from reset
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    we = 2'b00;
    card_number = {3'd4, 3'd1};
    session = 2'b00;
    req = 2'b11;
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(posedge clk);
      #1;
      if (ack != 2'b00) begin
        who[n] = int'(ack[1]);
        when[n] = c;
        val[n] = rdata;
        n++;
        if (n == 4) begin
          @(negedge clk);
          req = 2'b00;
        end
      end
    end
    chk("rr_count", 32'(n), 32'd4);
    for (int k = 0; k < n; k++) begin
      chk("rr_who", 32'(who[k]), 32'(k % 2));
      chk("rr_when", 32'(when[k]), 32'(3 + 4 * k));
      chk("rr_data", 32'(val[k]), (k % 2) ? 32'd444 : 32'd111);
    end

    // lock conflict
    access(0, 1'b0, 3, 20'd0, 1'b1, lat, rd, cf);
    chk("lk_owner_data", 32'(rd), 32'd333);
    chk("lk_owner_conflict", 32'(cf), 32'd0);
    e0 = en_cnt;
    access(1, 1'b0, 3, 20'd0, 1'b0, lat, rd, cf);
    chk("lk_block_conflict", 32'(cf), 32'd1);
    chk("lk_block_rdata", 32'(rd), 32'd0);
    chk("lk_block_no_en", 32'(en_cnt - e0), 32'd0);
    chk("lk_block_lat", 32'(lat), 32'd3);
    @(negedge clk);
    session[0] = 1'b0;
    access(1, 1'b0, 3, 20'd0, 1'b0, lat, rd, cf);
    chk("lk_retry_conflict", 32'(cf), 32'd0);
    chk("lk_retry_data", 32'(rd), 32'd333);

    // reset mid-access, with a lock held on card 6
    access(0, 1'b0, 6, 20'd0, 1'b1, lat, rd, cf);
    chk("rm_lock_data", 32'(rd), 32'd666);
    @(negedge clk);
    req[0] = 1'b1;
    card_number[2:0] = 3'd5;
    @(posedge clk);
    #1;
    chk("rm_issue_en", 32'(mem_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_en_cleared", 32'(mem_en), 32'd0);
    chk("rm_ack_cleared", 32'(ack), 32'd0);
    req[0] = 1'b0;
    e0 = en_cnt;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk("rm_quiet", 32'({ack, mem_en}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    access(1, 1'b0, 6, 20'd0, 1'b0, lat, rd, cf);
    chk("rm_fresh_lat", 32'(lat), 32'd3);
    chk("rm_lock_gone", 32'(cf), 32'd0);
    chk("rm_fresh_data", 32'(rd), 32'd666);
    chk("rm_en_once", 32'(en_cnt - e0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
